// File: rtl/pb_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_event_pkg
// Description : Shared state encoding and counter sizing for pb_event_classifier
// Revision    : 1.0 - initial release
// ============================================================================
package pb_event_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Counter only ever needs to reach the largest terminal value.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_event_classifier.sv
`default_nettype none
// ============================================================================
// Module      : pb_event_classifier
// Description : Classifies debounced button gestures into single click,
//               double click, long press and auto-repeat pulses
// Revision    : 1.0 - initial release
// ============================================================================
module pb_event_classifier
    import pb_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int GAP_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_WIDTH     = cnt_width(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic PB_pressed_status,
    input  logic PB_pressed_pulse,
    input  logic PB_released_pulse,
    output logic single_click_pulse,
    output logic double_click_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] c_zero     = '0;
    localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_long_end = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_gap_end  = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_rep_end  = CNT_WIDTH'(REPEAT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                   w_single;
    logic                   w_double;
    logic                   w_long;
    logic                   w_repeat;
    logic                   w_press;
    logic                   w_rel;

    // Coincident press and release pulses are a protocol violation; drop both.
    assign w_press = PB_pressed_pulse & ~PB_released_pulse;
    assign w_rel   = PB_released_pulse & ~PB_pressed_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= IDLE;
            r_cnt              <= c_zero;
            single_click_pulse <= 1'b0;
            double_click_pulse <= 1'b0;
            long_press_pulse   <= 1'b0;
            repeat_pulse       <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_cnt              <= w_cnt_nxt;
            single_click_pulse <= w_single;
            double_click_pulse <= w_double;
            long_press_pulse   <= w_long;
            repeat_pulse       <= w_repeat;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_single    = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_nxt = PRESS1;
                    w_cnt_nxt   = c_zero;
                end
            end
            PRESS1: begin
                if (w_rel) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = c_zero;
                end else if (!PB_pressed_status) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = c_zero;
                end else if (r_cnt == c_long_end) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = c_zero;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            GAP: begin
                if (w_press) begin
                    w_state_nxt = PRESS2;
                    w_cnt_nxt   = c_zero;
                end else if (r_cnt == c_gap_end) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = c_zero;
                    w_single    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            PRESS2: begin
                if (w_rel) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = c_zero;
                    w_double    = 1'b1;
                end else if (!PB_pressed_status) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = c_zero;
                end
            end
            HOLD: begin
                if (w_rel || !PB_pressed_status) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = c_zero;
                end else if (r_cnt == c_rep_end) begin
                    w_cnt_nxt   = c_zero;
                    w_repeat    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = c_zero;
            end
        endcase
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pb_event_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_event_classifier
// Description : Directed self-checking bench for pb_event_classifier
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_event_classifier;

    logic clk;
    logic rst;
    logic PB_pressed_status;
    logic PB_pressed_pulse;
    logic PB_released_pulse;
    logic single_click_pulse;
    logic double_click_pulse;
    logic long_press_pulse;
    logic repeat_pulse;
    logic busy;

    int passed;
    int failed;
    int total;
    int e;

    pb_event_classifier #(
        .LONG_CYCLES   (8),
        .GAP_CYCLES    (6),
        .REPEAT_CYCLES (4)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .PB_pressed_status  (PB_pressed_status),
        .PB_pressed_pulse   (PB_pressed_pulse),
        .PB_released_pulse  (PB_released_pulse),
        .single_click_pulse (single_click_pulse),
        .double_click_pulse (double_click_pulse),
        .long_press_pulse   (long_press_pulse),
        .repeat_pulse       (repeat_pulse),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector order: {single, double, long, repeat, busy}
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {single_click_pulse, double_click_pulse, long_press_pulse, repeat_pulse, busy};
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic pp, input logic rp);
        PB_pressed_status = st;
        PB_pressed_pulse  = pp;
        PB_released_pulse = rp;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        PB_pressed_status = 1'b0;
        PB_pressed_pulse  = 1'b0;
        PB_released_pulse = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = 0;
    endtask

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        e      = 0;
        do_reset();
        chk("reset", 5'b00000);

        // Single click: press 10, release 13 -> single after edge 19
        for (int i = 1; i <= 22; i++) begin
            step(e + 1 >= 10 && e + 1 < 13, e + 1 == 10, e + 1 == 13);
            chk("single", {e == 19, 1'b0, 1'b0, 1'b0, (e >= 10 && e < 19)});
        end

        // Double click: press 10, rel 12, press 15, rel 18 -> double after 18
        do_reset();
        for (int i = 1; i <= 22; i++) begin
            step((e + 1 >= 10 && e + 1 < 12) || (e + 1 >= 15 && e + 1 < 18),
                 e + 1 == 10 || e + 1 == 15, e + 1 == 12 || e + 1 == 18);
            chk("double", {1'b0, e == 18, 1'b0, 1'b0, (e >= 10 && e < 18)});
        end

        // Long press held to 30: long at 18, repeats at 22 and 26, edge-30 repeat lost to release
        do_reset();
        for (int i = 1; i <= 33; i++) begin
            step(e + 1 >= 10 && e + 1 < 30, e + 1 == 10, e + 1 == 30);
            chk("long_repeat", {1'b0, 1'b0, e == 18, (e == 22 || e == 26), (e >= 10 && e < 30)});
        end

        // Release on the long-press terminal edge: no long, single after GAP
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            step(e + 1 >= 10 && e + 1 < 18, e + 1 == 10, e + 1 == 18);
            chk("rel_at_long_end", {e == 24, 1'b0, 1'b0, 1'b0, (e >= 10 && e < 24)});
        end

        // Second press on the gap terminal edge: press wins, double at 20
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            step((e + 1 >= 10 && e + 1 < 12) || (e + 1 >= 18 && e + 1 < 20),
                 e + 1 == 10 || e + 1 == 18, e + 1 == 12 || e + 1 == 20);
            chk("press_at_gap_end", {1'b0, e == 20, 1'b0, 1'b0, (e >= 10 && e < 20)});
        end

        // Coincident press and release pulses in IDLE are ignored
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, e + 1 == 5, e + 1 == 5);
            chk("both_pulses_idle", 5'b00000);
        end

        // Status drop in HOLD without release pulse -> IDLE, no repeat
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            step(e + 1 >= 10 && e + 1 < 21, e + 1 == 10, 1'b0);
            chk("lost_release_hold", {1'b0, 1'b0, e == 18, 1'b0, (e >= 10 && e < 21)});
        end

        // Async reset while the long pulse is high
        do_reset();
        for (int i = 1; i <= 18; i++) begin
            step(e + 1 >= 10, e + 1 == 10, 1'b0);
        end
        chk("pre_async_reset", 5'b00101);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 5'b00000);
        #3;
        rst = 1'b0;
        e = 0;
        for (int i = 1; i <= 13; i++) begin
            step(e + 1 >= 3 && e + 1 < 5, e + 1 == 3, e + 1 == 5);
            chk("post_reset_single", {e == 11, 1'b0, 1'b0, 1'b0, (e >= 3 && e < 11)});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
